// File: rtl/bus_pkg.sv
// Shared bus definitions for the cache fill unit: request tag layout,
// memory type / direction constants, the controller state encoding and a tag builder.
package bus_pkg;

  localparam int TAG_W      = 13;
  localparam int TAG_RW_BIT = 12;
  localparam int TAG_MT_HI  = 11;
  localparam int TAG_MT_LO  = 8;

  localparam logic [3:0] MEMORY_TYPE = 4'b0001;
  localparam logic       RW_READ     = 1'b1;
  localparam logic       RW_WRITE    = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    WB_ADDR,
    WB_DATA,
    RD_ADDR,
    RD_DATA,
    DONE
  } fill_state_e;

  // Tag = {rw, MEMORY_TYPE, 8'h00}.
  function automatic logic [TAG_W-1:0] make_tag(input logic rw);
    logic [TAG_W-1:0] tag;
    tag                      = '0;
    tag[TAG_RW_BIT]          = rw;
    tag[TAG_MT_HI:TAG_MT_LO] = MEMORY_TYPE;
    return tag;
  endfunction

endpackage

// File: rtl/cache_fill_unit.sv
// Cache line fill / writeback controller: serialises dirty lines onto the
// bus arbiter and assembles read response beats into a full cache line.
module cache_fill_unit
  import bus_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int TAG_WIDTH = 13,
  parameter int BEATS     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   miss_req,
  input  logic [WIDTH-1:0]       miss_addr,
  input  logic                   wb_req,
  input  logic [WIDTH-1:0]       wb_addr,
  input  logic [WIDTH*BEATS-1:0] wb_line,
  output logic                   fill_valid,
  output logic [WIDTH*BEATS-1:0] fill_line,
  output logic                   wb_done,
  output logic                   busy,
  output logic [WIDTH-1:0]       req,
  output logic [TAG_WIDTH-1:0]   reqtag,
  output logic                   reqcyc,
  input  logic                   reqack,
  input  logic [WIDTH-1:0]       resp,
  input  logic                   respcyc,
  output logic                   respack
);

  localparam int               CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  fill_state_e                  state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [WIDTH-1:0]             addr_q, addr_d;
  logic [BEATS-1:0][WIDTH-1:0]  wb_beats_q, wb_beats_d;
  logic [BEATS-1:0][WIDTH-1:0]  fill_beats_q, fill_beats_d;
  logic                         is_wb_q, is_wb_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value; blocking here would create ordering-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wb_beats_q   <= '0;
      fill_beats_q <= '0;
      is_wb_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wb_beats_q   <= wb_beats_d;
      fill_beats_q <= fill_beats_d;
      is_wb_q      <= is_wb_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wb_beats_d   = wb_beats_q;
    fill_beats_d = fill_beats_q;
    is_wb_d      = is_wb_q;
    req          = '0;
    reqtag       = '0;
    reqcyc       = 1'b0;
    respack      = 1'b0;
    fill_valid   = 1'b0;
    wb_done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Writeback wins so the dirty victim leaves before its slot is refilled.
        if (wb_req) begin
          state_d    = WB_ADDR;
          addr_d     = wb_addr;
          wb_beats_d = wb_line;
          is_wb_d    = 1'b1;
          cnt_d      = '0;
        end else if (miss_req) begin
          state_d = RD_ADDR;
          addr_d  = miss_addr;
          is_wb_d = 1'b0;
          cnt_d   = '0;
        end
      end

      WB_ADDR: begin
        reqcyc = 1'b1;
        req    = addr_q;
        reqtag = TAG_WIDTH'(make_tag(RW_WRITE));
        if (reqack) begin
          state_d = WB_DATA;
          cnt_d   = '0;
        end
      end

      WB_DATA: begin
        reqcyc = 1'b1;
        req    = wb_beats_q[cnt_q];
        reqtag = TAG_WIDTH'(make_tag(RW_WRITE));
        if (reqack) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      RD_ADDR: begin
        reqcyc = 1'b1;
        req    = addr_q;
        reqtag = TAG_WIDTH'(make_tag(RW_READ));
        if (reqack) begin
          state_d = RD_DATA;
          cnt_d   = '0;
        end
      end

      RD_DATA: begin
        respack = respcyc;
        if (respcyc) begin
          fill_beats_d[cnt_q] = resp;
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        fill_valid = ~is_wb_q;
        wb_done    = is_wb_q;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign fill_line = fill_beats_q;

endmodule

// File: tb/tb_cache_fill_unit.sv
// Directed bench for cache_fill_unit: fill, writeback, priority, gapped
// responses, stray responses and mid-transaction reset.
module tb_cache_fill_unit;

  localparam int W  = 64;
  localparam int TW = 13;
  localparam int B  = 8;
  localparam int LW = W * B;

  localparam logic [TW-1:0] TAG_RD = 13'h1100;
  localparam logic [TW-1:0] TAG_WR = 13'h0100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          miss_req = 1'b0;
  logic [W-1:0]  miss_addr = '0;
  logic          wb_req = 1'b0;
  logic [W-1:0]  wb_addr = '0;
  logic [LW-1:0] wb_line = '0;
  logic          fill_valid;
  logic [LW-1:0] fill_line;
  logic          wb_done;
  logic          busy;
  logic [W-1:0]  req;
  logic [TW-1:0] reqtag;
  logic          reqcyc;
  logic          reqack = 1'b0;
  logic [W-1:0]  resp = '0;
  logic          respcyc = 1'b0;
  logic          respack;

  int checks   = 0;
  int failures = 0;

  cache_fill_unit #(.WIDTH(W), .TAG_WIDTH(TW), .BEATS(B)) dut (
    .clk        (clk),
    .reset      (reset),
    .miss_req   (miss_req),
    .miss_addr  (miss_addr),
    .wb_req     (wb_req),
    .wb_addr    (wb_addr),
    .wb_line    (wb_line),
    .fill_valid (fill_valid),
    .fill_line  (fill_line),
    .wb_done    (wb_done),
    .busy       (busy),
    .req        (req),
    .reqtag     (reqtag),
    .reqcyc     (reqcyc),
    .reqack     (reqack),
    .resp       (resp),
    .respcyc    (respcyc),
    .respack    (respack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] observed, input logic [LW-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [LW-1:0] mk_line(input logic [W-1:0] base, input logic [W-1:0] stride);
    logic [LW-1:0] l;
    l = '0;
    for (int i = 0; i < B; i++) l[i*W +: W] = base + W'(i) * stride;
    return l;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_reqcyc"}, reqcyc, 1'b0);
    check({tag, "_respack"}, respack, 1'b0);
    check({tag, "_fill_valid"}, fill_valid, 1'b0);
    check({tag, "_wb_done"}, wb_done, 1'b0);
    check({tag, "_req"}, req, '0);
    check({tag, "_reqtag"}, reqtag, '0);
  endtask

  // Read fill with the address accepted on its first cycle and back-to-back beats.
  task automatic run_fill(input string tag, input logic [W-1:0] addr, input logic [W-1:0] base);
    logic [LW-1:0] exp_line;
    exp_line  = mk_line(base, 1);
    miss_addr = addr;
    miss_req  = 1'b1;
    step();
    miss_req = 1'b0;
    reqack   = 1'b1;
    #1;
    check({tag, "_req_addr"}, req, addr);
    check({tag, "_reqtag"}, reqtag, TAG_RD);
    step();
    reqack = 1'b0;
    for (int i = 0; i < B; i++) begin
      respcyc = 1'b1;
      resp    = base + W'(i);
      #1;
      check({tag, "_respack"}, respack, 1'b1);
      step();
    end
    respcyc = 1'b0;
    #1;
    check({tag, "_fill_valid"}, fill_valid, 1'b1);
    check({tag, "_fill_line"}, fill_line, exp_line);
    step();
    check({tag, "_fill_valid_drop"}, fill_valid, 1'b0);
    check({tag, "_busy_drop"}, busy, 1'b0);
  endtask

  initial begin
    logic [LW-1:0] exp_line;
    logic [W-1:0]  exp_req;

    // Reset
    step();
    step();
    reset = 1'b0;
    #1;
    check_idle_zero("reset");
    check("reset_fill_line", fill_line, '0);

    // Fill 0x1000, address ack on the 2nd cycle, beats 0x11..0x88
    miss_addr = 64'h1000;
    miss_req  = 1'b1;
    step();
    miss_req = 1'b0;
    #1;
    check("fill_busy", busy, 1'b1);
    check("fill_reqcyc", reqcyc, 1'b1);
    check("fill_req_c1", req, 64'h1000);
    check("fill_tag", reqtag, TAG_RD);
    step();
    reqack = 1'b1;
    #1;
    check("fill_req_c2", req, 64'h1000);
    step();
    reqack = 1'b0;
    #1;
    check("fill_reqcyc_drop", reqcyc, 1'b0);
    check("fill_respack_idle", respack, 1'b0);
    for (int i = 0; i < B; i++) begin
      respcyc = 1'b1;
      resp    = W'(i + 1) * 64'h11;
      #1;
      check("fill_respack", respack, 1'b1);
      check("fill_no_early_valid", fill_valid, 1'b0);
      step();
    end
    respcyc = 1'b0;
    #1;
    exp_line = mk_line(64'h11, 64'h11);
    check("fill_valid", fill_valid, 1'b1);
    check("fill_line", fill_line, exp_line);
    check("fill_wb_done", wb_done, 1'b0);
    check("fill_done_reqcyc", reqcyc, 1'b0);
    step();
    check("fill_valid_pulse", fill_valid, 1'b0);
    check("fill_busy_end", busy, 1'b0);
    check("fill_line_hold", fill_line, exp_line);

    // Writeback 0x2000, beats 0xA0..0xA7, ack every 2nd cycle
    wb_addr = 64'h2000;
    wb_line = mk_line(64'hA0, 1);
    wb_req  = 1'b1;
    step();
    wb_req  = 1'b0;
    wb_line = '0;
    for (int k = 0; k <= B; k++) begin
      exp_req = (k == 0) ? 64'h2000 : 64'hA0 + W'(k - 1);
      reqack  = 1'b0;
      #1;
      check("wb_req_hold", req, exp_req);
      check("wb_reqcyc", reqcyc, 1'b1);
      check("wb_tag", reqtag, TAG_WR);
      step();
      reqack = 1'b1;
      #1;
      check("wb_req_ack", req, exp_req);
      step();
    end
    reqack = 1'b0;
    #1;
    check("wb_done", wb_done, 1'b1);
    check("wb_no_fill_valid", fill_valid, 1'b0);
    check("wb_done_reqcyc", reqcyc, 1'b0);
    check("wb_done_busy", busy, 1'b1);
    step();
    check("wb_done_pulse", wb_done, 1'b0);
    check("wb_busy_end", busy, 1'b0);

    // Simultaneous requests: writeback first, held miss follows
    wb_addr   = 64'h3000;
    wb_line   = mk_line(64'hB0, 1);
    miss_addr = 64'h4000;
    wb_req    = 1'b1;
    miss_req  = 1'b1;
    step();
    wb_req = 1'b0;
    reqack = 1'b1;
    #1;
    check("both_wb_first", req, 64'h3000);
    check("both_wb_tag", reqtag, TAG_WR);
    step();
    for (int i = 0; i < B; i++) begin
      #1;
      check("both_wb_beat", req, 64'hB0 + W'(i));
      step();
    end
    reqack = 1'b0;
    #1;
    check("both_wb_done", wb_done, 1'b1);
    step();
    check("both_idle_gap", busy, 1'b0);
    check("both_idle_reqcyc", reqcyc, 1'b0);
    step();
    miss_req = 1'b0;
    reqack   = 1'b1;
    #1;
    check("both_rd_addr", req, 64'h4000);
    check("both_rd_tag", reqtag, TAG_RD);
    step();
    reqack = 1'b0;

    // Gapped responses: three idle cycles before each beat
    for (int i = 0; i < B; i++) begin
      for (int g = 0; g < 3; g++) begin
        respcyc = 1'b0;
        resp    = 64'hDEAD;
        #1;
        check("gap_respack_low", respack, 1'b0);
        check("gap_busy", busy, 1'b1);
        step();
      end
      respcyc = 1'b1;
      resp    = 64'h100 + W'(i);
      #1;
      check("gap_respack_high", respack, 1'b1);
      step();
    end
    respcyc = 1'b0;
    #1;
    exp_line = mk_line(64'h100, 1);
    check("gap_fill_valid", fill_valid, 1'b1);
    check("gap_fill_line", fill_line, exp_line);
    step();
    check("gap_fill_valid_pulse", fill_valid, 1'b0);

    // Stray response beat while idle
    respcyc = 1'b1;
    resp    = 64'hFFFF;
    #1;
    check("stray_respack", respack, 1'b0);
    step();
    check("stray_busy", busy, 1'b0);
    check("stray_fill_line", fill_line, exp_line);
    respcyc = 1'b0;

    // Reset after four read beats
    miss_addr = 64'h5000;
    miss_req  = 1'b1;
    step();
    miss_req = 1'b0;
    reqack   = 1'b1;
    step();
    reqack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      respcyc = 1'b1;
      resp    = 64'h50 + W'(i);
      step();
    end
    respcyc = 1'b0;
    reset   = 1'b1;
    step();
    #1;
    check_idle_zero("rst_mid");
    check("rst_mid_fill_line", fill_line, '0);
    reset = 1'b0;
    step();
    check("rst_after_fill_valid", fill_valid, 1'b0);
    check("rst_after_busy", busy, 1'b0);
    run_fill("fresh", 64'h6000, 64'h60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
